// File: rtl/vga_receiver.sv
// -----------------------------------------------------------------------------
// vga_receiver
//
// Recovers pixel coordinates and colour from an incoming VGA-style stream
// (separate active-low h_sync / v_sync plus 4-bit RGB). It measures line and
// frame lengths against the configured timing, locks after two consecutive
// clean frames, and only then reports active pixels.
//
// Pipeline: inputs are registered once (sample stage), decoded from the
// sample stage, and every output is registered. Input-to-output latency is
// 2 clk.
//
// Ports:
//   clk          pixel clock, sole clock
//   rst          synchronous active-high reset
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
//   rin/gin/bin  incoming 4-bit colour
//   r/g/b        captured colour, 0 outside valid pixels
//   screenX      active pixel column, 0 outside valid pixels
//   screenY      active line, 0 outside valid pixels
//   pixel_valid  r/g/b/screenX/screenY describe an active pixel while locked
//   frame_start  one-cycle pulse with the valid pixel at (0,0)
//   locked       timing acquired
//   sync_err     one-cycle pulse whenever lock (or acquisition) is lost
//
// Optional feature, macro VGA_RX_MEASURE_EN:
//   h_period     last measured line period in clocks (11 bit)
//   v_period     last measured frame period in lines (10 bit)
//   Without the macro these ports and their logic do not exist.
// -----------------------------------------------------------------------------
module vga_receiver #(
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_TOL  = 1,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [3:0] rin,
  input  logic [3:0] gin,
  input  logic [3:0] bin,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [9:0] screenX,
  output logic [8:0] screenY,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [10:0] h_period,
  output logic [9:0]  v_period
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [11:0] H_PER_MIN = 12'(H_TOTAL - H_TOL);
  localparam logic [11:0] H_PER_MAX = 12'(H_TOTAL + H_TOL);
  localparam logic [10:0] V_PER     = 11'(V_TOTAL);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // sample stage and edge-detect history
  logic       hs_smp_q, vs_smp_q, hs_prev_q, vs_prev_q;
  logic [3:0] r_smp_q, g_smp_q, b_smp_q;

  // timing state
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vpend_q, vpend_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  good_cnt_q, good_cnt_d;

  // decode
  logic        hs_start_s, vs_start_s, reload_s;
  logic [11:0] line_per_s;
  logic [10:0] frame_per_s;
  logic        line_bad_s, frame_bad_s, hsat_s, fail_s, active_s;

  // output registers
  logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [9:0] sx_q, sx_d;
  logic [8:0] sy_q, sy_d;
  logic       valid_q, valid_d, fs_q, fs_d, locked_q, locked_d, err_q, err_d;

  // Edge detection, counter next-state and timing checks
  always_comb begin
    hs_start_s  = hs_prev_q & ~hs_smp_q;
    vs_start_s  = vs_prev_q & ~vs_smp_q;
    // a pending (or simultaneous) vsync start is consumed by the hsync start
    reload_s    = hs_start_s & (vpend_q | vs_start_s);
    line_per_s  = {1'b0, hcnt_q} + 12'd1;
    frame_per_s = {1'b0, vcnt_q} + 11'd1;

    if (hs_start_s) begin
      hcnt_d = 11'd0;
    end else if (hcnt_q == 11'h7FF) begin
      hcnt_d = hcnt_q;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end

    if (reload_s) begin
      vcnt_d = 10'd0;
    end else if (hs_start_s && (vcnt_q != 10'h3FF)) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end

    if (reload_s) begin
      vpend_d = 1'b0;
    end else if (vs_start_s) begin
      vpend_d = 1'b1;
    end else begin
      vpend_d = vpend_q;
    end

    line_bad_s  = hs_start_s && ((line_per_s < H_PER_MIN) || (line_per_s > H_PER_MAX));
    frame_bad_s = reload_s && (frame_per_s != V_PER);
    // a missing hsync shows up as the counter pinning at its maximum
    hsat_s      = (hcnt_d == 11'h7FF);
    fail_s      = line_bad_s | frame_bad_s | hsat_s;
  end

  // Lock state machine; a reload that survives the checks is a good frame
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (reload_s) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = 2'd0;
        end else begin
          state_d    = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        if (fail_s) begin
          state_d    = ST_SEARCH;
          good_cnt_d = 2'd0;
        end else if (reload_s) begin
          if (good_cnt_q == 2'd1) begin
            state_d    = ST_LOCKED;
            good_cnt_d = 2'd0;
          end else begin
            good_cnt_d = good_cnt_q + 2'd1;
          end
        end else begin
          good_cnt_d = good_cnt_q;
        end
      end
      ST_LOCKED: begin
        if (fail_s) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        good_cnt_d = 2'd0;
      end
    endcase
  end

  // Output next-state: uses the counters/state that describe the sample
  // currently in the sample stage, so a lost lock blanks the very next output
  always_comb begin
    active_s = (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
               (vcnt_d >= V_START) && (vcnt_d <= V_END);
    locked_d = (state_d == ST_LOCKED);
    valid_d  = locked_d && active_s;
    err_d    = (state_q != ST_SEARCH) && (state_d == ST_SEARCH);
    if (valid_d) begin
      sx_d = 10'(hcnt_d - H_START);
      sy_d = 9'(vcnt_d - V_START);
      r_d  = r_smp_q;
      g_d  = g_smp_q;
      b_d  = b_smp_q;
    end else begin
      sx_d = 10'd0;
      sy_d = 9'd0;
      r_d  = 4'd0;
      g_d  = 4'd0;
      b_d  = 4'd0;
    end
    fs_d = valid_d && (sx_d == 10'd0) && (sy_d == 9'd0);
  end

  // Sample stage: syncs idle high, colour idle zero
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_smp_q  <= 1'b1;
      vs_smp_q  <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      r_smp_q   <= 4'd0;
      g_smp_q   <= 4'd0;
      b_smp_q   <= 4'd0;
    end else begin
      hs_smp_q  <= h_sync;
      vs_smp_q  <= v_sync;
      hs_prev_q <= hs_smp_q;
      vs_prev_q <= vs_smp_q;
      r_smp_q   <= rin;
      g_smp_q   <= gin;
      b_smp_q   <= bin;
    end
  end

  // Counters and lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= 11'd0;
      vcnt_q     <= 10'd0;
      vpend_q    <= 1'b0;
      state_q    <= ST_SEARCH;
      good_cnt_q <= 2'd0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      vpend_q    <= vpend_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= 4'd0;
      g_q      <= 4'd0;
      b_q      <= 4'd0;
      sx_q     <= 10'd0;
      sy_q     <= 9'd0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign screenX     = sx_q;
  assign screenY     = sy_q;
  assign pixel_valid = valid_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;

`ifdef VGA_RX_MEASURE_EN
  // the first sync edge after reset ends a partial period, so it is skipped
  logic        h_seen_q, v_seen_q;
  logic [10:0] h_period_q;
  logic [9:0]  v_period_q;

  // Period measurement registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_seen_q   <= 1'b0;
      v_seen_q   <= 1'b0;
      h_period_q <= 11'd0;
      v_period_q <= 10'd0;
    end else begin
      if (hs_start_s) begin
        h_seen_q <= 1'b1;
        if (h_seen_q) begin
          h_period_q <= (hcnt_q == 11'h7FF) ? 11'h7FF : (hcnt_q + 11'd1);
        end else begin
          h_period_q <= h_period_q;
        end
      end else begin
        h_seen_q   <= h_seen_q;
        h_period_q <= h_period_q;
      end
      if (reload_s) begin
        v_seen_q <= 1'b1;
        if (v_seen_q) begin
          v_period_q <= (vcnt_q == 10'h3FF) ? 10'h3FF : (vcnt_q + 10'd1);
        end else begin
          v_period_q <= v_period_q;
        end
      end else begin
        v_seen_q   <= v_seen_q;
        v_period_q <= v_period_q;
      end
    end
  end

  assign h_period = h_period_q;
  assign v_period = v_period_q;
`endif

endmodule

// File: tb/tb_vga_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_receiver
//
// Directed bench for vga_receiver using a reduced timing (28 clk x 12 lines,
// 16 x 6 active) so that many frames fit in a short run. A monitor counts
// output events; directed checks compare those counts and sampled outputs
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_vga_receiver;

  localparam int HT   = 28;   // 4 + 4 + 16 + 4
  localparam int VT   = 12;   // 2 + 2 + 6 + 2
  localparam int NPIX = 96;   // 16 x 6

  logic       clk, rst, h_sync, v_sync;
  logic [3:0] rin, gin, bin, r, g, b;
  logic [9:0] screenX;
  logic [8:0] screenY;
  logic       pixel_valid, frame_start, locked, sync_err;
`ifdef VGA_RX_MEASURE_EN
  logic [10:0] h_period;
  logic [9:0]  v_period;
`endif

  vga_receiver #(
    .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4), .H_TOL(1),
    .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(2)
  ) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
    .rin(rin), .gin(gin), .bin(bin),
    .r(r), .g(g), .b(b),
    .screenX(screenX), .screenY(screenY),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err)
`ifdef VGA_RX_MEASURE_EN
    , .h_period(h_period), .v_period(v_period)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // event counters filled by the monitor
  int valid_cnt = 0, fs_cnt = 0, err_cnt = 0;
  int col_bad = 0, zero_bad = 0, fs_bad = 0;
  int fs_cyc = 0, lock_rise_cyc = 0, act_cyc = 0, fr_cyc = 0;
  logic locked_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (pixel_valid) begin
      valid_cnt++;
      if ((r != screenX[3:0]) || (g != screenY[3:0]) || (b != 4'hA)) col_bad++;
    end else if ((r != 4'd0) || (g != 4'd0) || (b != 4'd0) ||
                 (screenX != 10'd0) || (screenY != 9'd0)) begin
      zero_bad++;
    end
    if (frame_start) begin
      fs_cnt++;
      fs_cyc = cyc;
      if (!pixel_valid || (screenX != 10'd0) || (screenY != 9'd0)) fs_bad++;
    end
    if (sync_err) err_cnt++;
    if (locked && !locked_prev) lock_rise_cyc = cyc;
    locked_prev = locked;
  end

  // One line of stimulus; line index l selects vsync (l<2) and the green value
  task automatic send_line(input int len, input int l);
    logic [31:0] xv, yv;
    for (int h = 0; h < len; h++) begin
      @(posedge clk); #1;
      h_sync = (h < 4) ? 1'b0 : 1'b1;
      v_sync = (l < 2) ? 1'b0 : 1'b1;
      xv  = h - 8;
      yv  = l - 4;
      rin = xv[3:0];
      gin = yv[3:0];
      bin = 4'hA;
      if (h == 0 && l == 0) fr_cyc = cyc;
      if (h == 8 && l == 4) act_cyc = cyc;
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_idx, input int bad_len);
    for (int l = 0; l < nlines; l++) send_line((l == bad_idx) ? bad_len : HT, l);
  endtask

  int v0, f0, e0;

  initial begin
    rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    rin = 4'd0; gin = 4'd0; bin = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_valid", pixel_valid, 0);
    check_eq("rst_fs_err", {frame_start, sync_err}, 0);
    check_eq("rst_data", {r, g, b, screenX, screenY}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // frames 1-2: acquiring
    v0 = valid_cnt;
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check_eq("acq_valid", valid_cnt - v0, 0);
    check_eq("acq_locked", locked, 0);
    check_eq("acq_err", err_cnt, 0);

    // frame 3: lock at its start
    v0 = valid_cnt; f0 = fs_cnt;
    send_frame(VT, -1, 0);
    check_eq("lock_rise", lock_rise_cyc, fr_cyc + 2);
    check_eq("f3_valid", valid_cnt - v0, NPIX);
    check_eq("f3_fs", fs_cnt - f0, 1);
    check_eq("fs_latency", fs_cyc - act_cyc, 2);

    // frame 4 nominal
    v0 = valid_cnt; f0 = fs_cnt;
    send_frame(VT, -1, 0);
    check_eq("f4_valid", valid_cnt - v0, NPIX);
    check_eq("f4_fs", fs_cnt - f0, 1);

    // frame 5: one line of HT+1 is within tolerance
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(VT, 5, HT + 1);
    check_eq("tol_locked", locked, 1);
    check_eq("tol_valid", valid_cnt - v0, NPIX);
    check_eq("tol_err", err_cnt - e0, 0);

    // frame 6: line 5 of HT+2 drops lock at the start of line 6
    v0 = valid_cnt; e0 = err_cnt; f0 = fs_cnt;
    send_frame(VT, 5, HT + 2);
    check_eq("badline_err", err_cnt - e0, 1);
    check_eq("badline_locked", locked, 0);
    check_eq("badline_pv", pixel_valid, 0);
    check_eq("badline_valid", valid_cnt - v0, 32);
    check_eq("badline_fs", fs_cnt - f0, 1);

    // frames 7-9: search -> acquire -> locked at frame 9
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check_eq("relock1_valid", valid_cnt - v0, 0);
    v0 = valid_cnt;
    send_frame(VT, -1, 0);
    check_eq("relock1_f9", valid_cnt - v0, NPIX);
    check_eq("relock1_locked", locked, 1);
    check_eq("relock1_err", err_cnt - e0, 0);

    // frame 10 short by one line: error at the next reload
    e0 = err_cnt;
    send_frame(VT - 1, -1, 0);
    v0 = valid_cnt;
    send_frame(VT, -1, 0);
    check_eq("shortfr_err", err_cnt - e0, 1);
    check_eq("shortfr_locked", locked, 0);
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check_eq("shortfr_valid", valid_cnt - v0, 0);
    v0 = valid_cnt;
    send_frame(VT, -1, 0);
    check_eq("relock2_valid", valid_cnt - v0, NPIX);
    check_eq("relock2_locked", locked, 1);

    // missing hsync: counter saturation drops lock once
    e0 = err_cnt;
    for (int i = 0; i < 2100; i++) begin
      @(posedge clk); #1;
      h_sync = 1'b1; v_sync = 1'b1;
    end
    check_eq("hsat_err", err_cnt - e0, 1);
    check_eq("hsat_locked", locked, 0);

    // relock, then reset mid-frame
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    for (int l = 0; l < 5; l++) send_line(HT, l);
    check_eq("pre_rst_locked", locked, 1);
    e0 = err_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_valid", pixel_valid, 0);
    check_eq("mid_rst_fs_err", {frame_start, sync_err}, 0);
    check_eq("mid_rst_data", {r, g, b, screenX, screenY}, 0);
`ifdef VGA_RX_MEASURE_EN
    check_eq("hper_rst", h_period, 0);
`endif
    for (int l = 5; l < VT; l++) begin
      send_line(HT, l);
`ifdef VGA_RX_MEASURE_EN
      if (l == 6) check_eq("hper_after", h_period, HT);
`endif
    end
    send_frame(VT, -1, 0);
    check_eq("post_rst_err", err_cnt - e0, 0);
    check_eq("post_rst_locked", locked, 0);

    check_eq("colour_ramp", col_bad, 0);
    check_eq("blank_zero", zero_bad, 0);
    check_eq("fs_position", fs_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_receiver.md
VGA_RECEIVER -- requirements
Module: vga_receiver

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
 H_SYNC, 96, hsync pulse width in clocks; H_BP, 48, back porch; H_ACT, 640, active pixels; H_FP, 16, front porch; H_TOL, 1, allowed ± line-length deviation in clocks;
 V_SYNC, 2, vsync width in lines; V_BP, 33, back porch lines; V_ACT, 480, active lines; V_FP, 10, front porch lines.
REQ-002 H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP (derived, not overridable).
REQ-003 Ports (name direction width meaning) SHALL be:
 clk input 1 pixel clock, 25 MHz, sole clock;
 rst input 1 synchronous active-high reset;
 h_sync input 1 horizontal sync, active low;
 v_sync input 1 vertical sync, active low;
 rin/gin/bin input 4 each, incoming colour;
 r/g/b output 4 each, captured colour;
 screenX output 10 active pixel column; screenY output 9 active line;
 pixel_valid output 1 r/g/b/screenX/screenY are an active pixel;
 frame_start output 1 one-cycle pulse at pixel (0,0);
 locked output 1 timing acquired;
 sync_err output 1 one-cycle pulse on timing violation.

Function
REQ-004 All inputs SHALL be registered once (sample stage) before any decode; all outputs SHALL be registered; input-to-output latency = 2 clk.
REQ-005 hsync start = sampled h_sync 1->0; vsync start = sampled v_sync 1->0.
REQ-006 hcnt (11 bit) SHALL load 0 on hsync start, else increment, saturating at 2047.
REQ-007 A vsync start SHALL set vpend; at the next hsync start (including the same cycle) vcnt SHALL load 0 and clear vpend; other hsync starts increment vcnt (10 bit, saturating at 1023).
REQ-008 Line period = hcnt+1 at hsync start; line good iff |period - H_TOTAL| <= H_TOL.
REQ-009 Frame period = vcnt+1 when vcnt reloads; frame good iff period == V_TOTAL and every line in it was good.
REQ-010 FSM states SEARCH, ACQUIRE, LOCKED:
 SEARCH -> ACQUIRE on first vcnt reload;
 ACQUIRE -> LOCKED after 2 consecutive good frames;
 ACQUIRE/LOCKED -> SEARCH on any bad line, bad frame, or hcnt reaching 2047;
 locked = 1 only in LOCKED.
REQ-011 sync_err SHALL pulse one cycle on every transition into SEARCH other than by reset; it SHALL NOT pulse while already in SEARCH.
REQ-012 Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
REQ-013 pixel_valid = locked AND active; when valid, screenX = hcnt-(H_SYNC+H_BP), screenY = vcnt-(V_SYNC+V_BP), and r/g/b = sampled colour; otherwise all five are 0.
REQ-014 frame_start SHALL pulse with pixel_valid at screenX=0, screenY=0 only.
REQ-015 Loss of lock mid-line SHALL force pixel_valid to 0 from the next output cycle.

Reset
REQ-016 On rst: FSM = SEARCH; hcnt, vcnt, vpend, good-frame count, and sample registers = 0 (sync samples = 1); all outputs = 0.
REQ-017 rst asserted mid-frame SHALL take effect on the next clk edge, and reacquisition SHALL require a fresh vsync start.

Configuration
REQ-018 Macro VGA_RX_MEASURE_EN defined: add outputs h_period (11 bit) and v_period (10 bit), holding the last measured line and frame periods, updated on each hsync start and each vcnt reload respectively, reset to 0.
REQ-019 Macro undefined: these ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-020 Nominal 800x525 timing for 3 frames -> locked rises at the start of frame 3; frame_start pulses once per frame; pixel (0,0) appears 2 clk after the first active input sample.
REQ-021 Colour ramp rin=screenX[3:0] -> r equals screenX[3:0] on every valid cycle; exactly 640x480 valid cycles per locked frame.
REQ-022 Line lengths 801 and then 802 while locked -> 801 holds lock; 802 gives a sync_err pulse, locked=0, pixel_valid=0.
REQ-023 Frame of 524 lines while locked -> sync_err at the vcnt reload; relock after 2 further good frames.
REQ-024 h_sync held high for 2100 clk -> sync_err when hcnt hits 2047; remains in SEARCH.
REQ-025 rst pulsed mid-frame -> all outputs 0 the next cycle; no sync_err; with VGA_RX_MEASURE_EN, h_period=0 then 800 after the next line.
